// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the registered request record.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  typedef struct packed {
    logic        write;
    size_e       size;
    logic        is_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian byte-lane handling: extracts and extends load data, and
// merges sub-word store data into a previously read memory word.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_signed,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  shamt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wd_shifted;
  logic [3:0]  lane_en;

  assign shamt      = {lane, 3'b000};
  assign byte_sel   = rd_word[shamt +: 8];
  assign half_sel   = lane[1] ? rd_word[31:16] : rd_word[15:0];
  assign wd_shifted = wdata << shamt;

  always_comb begin
    lane_en   = 4'b1111;
    load_data = rd_word;
    case (size)
      SZ_BYTE: begin
        lane_en   = 4'b0001 << lane;
        load_data = {{24{is_signed & byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        lane_en   = 4'b0011 << {lane[1], 1'b0};
        load_data = {{16{is_signed & half_sel[15]}}, half_sel};
      end
      default: begin
        lane_en   = 4'b1111;
        load_data = rd_word;
      end
    endcase
  end

  // Each lane takes the shifted store byte when enabled, else keeps memory.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign merged_word[8*gi +: 8] = lane_en[gi] ? wd_shifted[8*gi +: 8]
                                                : rd_word[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request port and a
// word-wide data memory; sub-word stores use read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] Address,
  output logic [31:0] Write_Data,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] Read_Data
);

  localparam int unsigned WORD_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wr_word_q, wr_word_d;

  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [29:0] word_idx;
  logic        req_fault;
  logic        accept;

  assign word_idx = req_addr[31:2];
  assign accept   = req_valid && (state_q == IDLE);

  always_comb begin
    req_fault = 1'b0;
    case (size_e'(req_size))
      SZ_BYTE: req_fault = 1'b0;
      SZ_HALF: req_fault = req_addr[0];
      SZ_WORD: req_fault = |req_addr[1:0];
      default: req_fault = 1'b1;
    endcase
    // The first term catches wide addresses cheaply; the second handles non-power-of-two depths.
    if ((|word_idx[29:WORD_IDX_W]) || ({2'b00, word_idx} >= MEM_WORDS)) begin
      req_fault = 1'b1;
    end
  end

  lsu_lane_align u_lane_align (
    .rd_word     (Read_Data),
    .wdata       (req_q.wdata),
    .lane        (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_signed   (req_q.is_signed),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    fault_d   = fault_q;
    rdata_d   = rdata_q;
    wr_word_d = wr_word_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = '{write:     req_write,
                    size:      size_e'(req_size),
                    is_signed: req_signed,
                    addr:      req_addr,
                    wdata:     req_wdata};
          fault_d   = req_fault;
          rdata_d   = '0;
          wr_word_d = req_wdata;
          if (req_fault) begin
            state_d = RESP;
          end else if (req_write && (size_e'(req_size) == SZ_WORD)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (req_q.write) begin
          wr_word_d = merged_word;
          state_d   = WR;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      fault_q   <= 1'b0;
      rdata_q   <= '0;
      wr_word_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      fault_q   <= fault_d;
      rdata_q   <= rdata_d;
      wr_word_q <= wr_word_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_fault = resp_valid & fault_q;
  assign resp_rdata = rdata_q;
  assign MemRead    = (state_q == RD);
  assign MemWrite   = (state_q == WR);
  assign Address    = {2'b00, req_q.addr[31:2]};
  assign Write_Data = wr_word_q;

endmodule
